// File: rtl/backbone_tx_pkg.sv
// backbone_pkg: types and constants shared by the backbone transmit path.
//   state_t    : transmit FSM state encoding
//   FP64_W     : width of one backbone element (raw FP64 bits)
//   FP64_ONE   : FP64 encoding of 1.0
//   j_width()  : element index/count width for a J-element vector
package backbone_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADED,
        ST_FIRST,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int unsigned FP64_W = 64;
    localparam logic [FP64_W-1:0] FP64_ONE = 64'h3FF0_0000_0000_0000;

    function automatic int unsigned j_width(input int unsigned j);
        return $clog2(j) + 1;
    endfunction

endpackage

// File: rtl/backbone_tx_if.sv
// backbone_tx_if: vector load / start controls and the element stream of
// backbone_tx.
//   backbone_vec, backbone_vec_tvalid : J packed FP64 values + load strobe
//   start                             : begin streaming the held vector
//   backbone, backbone_tvalid         : element stream
//   first_backbone                    : tags the first element of a stream
//   loaded, busy, done, load_err      : status
// Modports: slave = backbone_tx itself, master = the side that drives it.
interface backbone_tx_if
    import backbone_pkg::*;
#(
    parameter int unsigned J = 14
);
    logic [J*FP64_W-1:0] backbone_vec;
    logic                backbone_vec_tvalid;
    logic                start;
    logic [FP64_W-1:0]   backbone;
    logic                backbone_tvalid;
    logic                first_backbone;
    logic                loaded;
    logic                busy;
    logic                done;
    logic                load_err;

    modport slave (
        input  backbone_vec, backbone_vec_tvalid, start,
        output backbone, backbone_tvalid, first_backbone,
               loaded, busy, done, load_err
    );

    modport master (
        output backbone_vec, backbone_vec_tvalid, start,
        input  backbone, backbone_tvalid, first_backbone,
               loaded, busy, done, load_err
    );
endinterface

// File: rtl/backbone_tx_pacer.sv
// backbone_tx_pacer: idle-gap timer between emitted backbone elements.
//   clk, rst  : clock, synchronous active-high reset
//   gap_start : pulse on the cycle the FSM leaves an element for the gap
//   gap_done  : high on the last gap cycle (FSM emits the next element on
//               the following edge); with GAP=0 it simply follows gap_start
module backbone_tx_pacer #(
    parameter int unsigned GAP = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic gap_start,
    output logic gap_done
);

    if (GAP == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign gap_done       = gap_start;
    end else begin : g_count
        localparam int unsigned CW = (GAP > 1) ? $clog2(GAP) : 1;

        logic [CW-1:0] cnt_q, cnt_d;

        // Loaded with GAP-1 so the counter reads zero on the GAP-th gap cycle.
        always_comb begin
            cnt_d = cnt_q;
            if (gap_start) begin
                cnt_d = CW'(GAP - 1);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign gap_done = (cnt_q == '0);
    end

endmodule

// File: rtl/backbone_tx.sv
// backbone_tx: holds a J-element FP64 backbone vector and, on start, streams
// it one element per beat (optionally GAP idle cycles apart) to the v-input
// generator. The first element of each stream carries first_backbone.
//   clk, rst : clock, synchronous active-high reset
//   bus      : backbone_tx_if.slave (vector load, start, stream, status)
// Build option BACKBONE_TX_REVERSE_EN: stream elements J-1 down to 0 instead
// of 0 up to J-1; timing and counts are unchanged.
module backbone_tx
    import backbone_pkg::*;
#(
    parameter int unsigned J   = 14,
    parameter int unsigned GAP = 0
) (
    input  logic            clk,
    input  logic            rst,
    backbone_tx_if.slave    bus
);

    localparam int unsigned J_WIDTH = j_width(J);
    typedef logic [J_WIDTH-1:0] idx_t;

`ifdef BACKBONE_TX_REVERSE_EN
    localparam idx_t IDX_FIRST = idx_t'(J - 1);
    localparam idx_t IDX_LAST  = '0;
    function automatic idx_t idx_next(input idx_t i);
        return i - idx_t'(1);
    endfunction
`else
    localparam idx_t IDX_FIRST = '0;
    localparam idx_t IDX_LAST  = idx_t'(J - 1);
    function automatic idx_t idx_next(input idx_t i);
        return i + idx_t'(1);
    endfunction
`endif

    // Constant-index scan keeps the element select free of index-width games.
    function automatic logic [FP64_W-1:0] pick(input logic [J*FP64_W-1:0] v,
                                               input idx_t i);
        logic [FP64_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < J; k++) begin
            if (i == idx_t'(k)) begin
                r = v[k*FP64_W +: FP64_W];
            end
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    idx_t                idx_q, idx_d;
    logic [J*FP64_W-1:0] vec_q, vec_d;
    logic [FP64_W-1:0]   backbone_q, backbone_d;
    logic                tvalid_q, tvalid_d;
    logic                first_q, first_d;
    logic                loaded_q, loaded_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load_err_q, load_err_d;

    logic                gap_start;
    logic                gap_done;

    backbone_tx_pacer #(.GAP(GAP)) u_pacer (
        .clk       (clk),
        .rst       (rst),
        .gap_start (gap_start),
        .gap_done  (gap_done)
    );

    // Outputs are registered from the next state, so the element of FIRST
    // and SEND appears on the same edge that enters those states.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        backbone_d = backbone_q;
        tvalid_d   = 1'b0;
        first_d    = 1'b0;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        gap_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.backbone_vec_tvalid) begin
                    vec_d   = bus.backbone_vec;
                    state_d = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (bus.backbone_vec_tvalid) begin
                    vec_d = bus.backbone_vec;
                end else if (bus.start) begin
                    state_d  = ST_FIRST;
                    idx_d    = IDX_FIRST;
                    tvalid_d = 1'b1;
                    first_d  = 1'b1;
                end
            end
            ST_FIRST, ST_SEND: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_next(idx_q);
                    if (GAP == 0) begin
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                    end else begin
                        state_d   = ST_WAIT;
                        gap_start = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (gap_done) begin
                    state_d  = ST_SEND;
                    tvalid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_LOADED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q inside {ST_FIRST, ST_SEND, ST_WAIT}) && bus.backbone_vec_tvalid) begin
            load_err_d = 1'b1;
        end

        // Otherwise backbone holds the last emitted element.
        if (tvalid_d) begin
            backbone_d = pick(vec_q, idx_d);
        end

        busy_d   = state_d inside {ST_FIRST, ST_SEND, ST_WAIT};
        loaded_d = (state_d == ST_LOADED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            vec_q      <= '0;
            backbone_q <= '0;
            tvalid_q   <= 1'b0;
            first_q    <= 1'b0;
            loaded_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vec_q      <= vec_d;
            backbone_q <= backbone_d;
            tvalid_q   <= tvalid_d;
            first_q    <= first_d;
            loaded_q   <= loaded_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.backbone        = backbone_q;
    assign bus.backbone_tvalid = tvalid_q;
    assign bus.first_backbone  = first_q;
    assign bus.loaded          = loaded_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.load_err        = load_err_q;

endmodule

// File: tb/tb_backbone_tx.sv
// tb_backbone_tx: directed bench for backbone_tx with J=4.
//   dut0: GAP=0, driven from a per-cycle vector table
//   dut2: GAP=2, hand-written gap-spacing sequence
// Stream-order expectations follow BACKBONE_TX_REVERSE_EN when defined.
module tb_backbone_tx;
    import backbone_pkg::*;

    localparam int unsigned J = 4;

`ifdef BACKBONE_TX_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    // Vector A = {1.0, 2.0, 3.0, 4.0}, vector B = {5.0, 6.0, 7.0, 8.0}
    localparam logic [63:0] VA [4] = '{FP64_ONE, 64'h4000_0000_0000_0000,
                                       64'h4008_0000_0000_0000, 64'h4010_0000_0000_0000};
    localparam logic [63:0] VB [4] = '{64'h4014_0000_0000_0000, 64'h4018_0000_0000_0000,
                                       64'h401C_0000_0000_0000, 64'h4020_0000_0000_0000};

    // Expected flag word: {tvalid, first, loaded, busy, done, load_err}
    localparam logic [5:0] F_V = 6'b100000;
    localparam logic [5:0] F_F = 6'b010000;
    localparam logic [5:0] F_L = 6'b001000;
    localparam logic [5:0] F_B = 6'b000100;
    localparam logic [5:0] F_D = 6'b000010;
    localparam logic [5:0] F_E = 6'b000001;

    typedef struct {
        bit          rst;
        bit          ld;
        bit          vb;
        bit          st;
        logic [5:0]  eflags;
        logic [63:0] edata;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst2;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl[$];

    backbone_tx_if #(.J(J)) bus0 ();
    backbone_tx_if #(.J(J)) bus2 ();

    backbone_tx #(.J(J), .GAP(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    backbone_tx #(.J(J), .GAP(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    // Element value at stream position pos for the build's emit order.
    function automatic logic [63:0] el(input bit b, input int unsigned pos);
        int unsigned k;
        k = REV ? (J - 1 - pos) : pos;
        return b ? VB[k] : VA[k];
    endfunction

    function automatic logic [J*64-1:0] pack(input bit b);
        logic [J*64-1:0] r;
        for (int unsigned k = 0; k < J; k++) begin
            r[k*64 +: 64] = b ? VB[k] : VA[k];
        end
        return r;
    endfunction

    function automatic void add(input bit r, input bit ld, input bit vb, input bit st,
                                input logic [5:0] f, input logic [63:0] d);
        vec_t v;
        v.rst = r; v.ld = ld; v.vb = vb; v.st = st; v.eflags = f; v.edata = d;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] flags0();
        return {bus0.backbone_tvalid, bus0.first_backbone, bus0.loaded,
                bus0.busy, bus0.done, bus0.load_err};
    endfunction

    function automatic logic [5:0] flags2();
        return {bus2.backbone_tvalid, bus2.first_backbone, bus2.loaded,
                bus2.busy, bus2.done, bus2.load_err};
    endfunction

    initial begin
        // Record i: inputs held over one edge, outputs checked 1 time unit after it.
        add(1, 0, 0, 0, '0, '0);                    // reset
        add(0, 0, 0, 1, '0, '0);                    // start in IDLE ignored
        add(0, 1, 0, 0, F_L, '0);                   // load A
        add(0, 0, 0, 1, F_V | F_F | F_B, el(0, 0)); // start -> first element
        add(0, 0, 0, 0, F_V | F_B, el(0, 1));
        add(0, 0, 0, 0, F_V | F_B, el(0, 2));
        add(0, 0, 0, 0, F_V | F_B, el(0, 3));
        add(0, 0, 0, 0, F_D, el(0, 3));             // done, data held
        add(0, 0, 0, 0, F_L, el(0, 3));
        add(0, 1, 1, 1, F_L, el(0, 3));             // load B + start: load wins
        add(0, 0, 0, 0, F_L, el(0, 3));             // still no stream
        add(0, 0, 0, 1, F_V | F_F | F_B, el(1, 0)); // stream B
        add(0, 0, 0, 0, F_V | F_B, el(1, 1));
        add(0, 0, 0, 0, F_V | F_B, el(1, 2));
        add(0, 1, 0, 0, F_V | F_B | F_E, el(1, 3)); // load A while busy
        add(0, 0, 0, 0, F_D, el(1, 3));             // single load_err pulse
        add(0, 0, 0, 0, F_L, el(1, 3));
        add(0, 0, 0, 1, F_V | F_F | F_B, el(1, 0)); // replay keeps vector B
        add(0, 0, 0, 0, F_V | F_B, el(1, 1));
        add(0, 0, 0, 0, F_V | F_B, el(1, 2));
        add(1, 0, 0, 0, '0, '0);                    // reset mid-stream
        add(0, 0, 0, 1, '0, '0);                    // start after reset ignored
        add(0, 0, 0, 0, '0, '0);                    // no done pulse

        rst0 = 1'b1;
        rst2 = 1'b1;
        bus0.backbone_vec = '0; bus0.backbone_vec_tvalid = 1'b0; bus0.start = 1'b0;
        bus2.backbone_vec = '0; bus2.backbone_vec_tvalid = 1'b0; bus2.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset flags", 64'(flags0()), '0);
        chk("reset data", bus0.backbone, '0);
        rst0 = 1'b0;

        // Start pulses with nothing loaded: no stream for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            bus0.start = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("idle start %0d flags", i), 64'(flags0()), '0);
        end
        bus0.start = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst0                     = tbl[i].rst;
            bus0.backbone_vec_tvalid = tbl[i].ld;
            bus0.backbone_vec        = pack(tbl[i].vb);
            bus0.start               = tbl[i].st;
            @(posedge clk);
            #1;
            chk($sformatf("tbl[%0d] flags", i), 64'(flags0()), 64'(tbl[i].eflags));
            chk($sformatf("tbl[%0d] data", i), bus0.backbone, tbl[i].edata);
        end
        rst0 = 1'b0;
        bus0.backbone_vec_tvalid = 1'b0;
        bus0.start = 1'b0;

        // GAP=2: elements at t+1, t+4, t+7, t+10; done at t+11.
        rst2 = 1'b0;
        bus2.backbone_vec = pack(0);
        bus2.backbone_vec_tvalid = 1'b1;
        @(posedge clk);
        #1;
        bus2.backbone_vec_tvalid = 1'b0;
        chk("gap loaded", 64'(flags2()), 64'(F_L));
        bus2.start = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            logic [5:0]  ef;
            logic [63:0] ed;
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            ef = '0;
            if (c <= 10 && ((c - 1) % 3) == 0) ef = ef | F_V;
            if (c == 1)  ef = ef | F_F;
            if (c <= 10) ef = ef | F_B;
            if (c == 11) ef = ef | F_D;
            if (c == 12) ef = ef | F_L;
            ed = (c <= 10) ? el(0, (c - 1) / 3) : el(0, 3);
            chk($sformatf("gap t+%0d flags", c), 64'(flags2()), 64'(ef));
            chk($sformatf("gap t+%0d data", c), bus2.backbone, ed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
